snake_rate_generator: RTL and testbench
=======================================

# snake_rate_generator

Multi-channel programmable tick generator for the Snake game. Produces per-channel single-cycle `tick` strobes and 50 %-duty `square` waves from the 50 MHz system clock. Typical channels: snake movement rate, food blink, display scan. Periods reload glitch-free through a valid/ready configuration port. Each channel runs free-running or one-shot.

## Interface
- `NUM_CH`, 2: number of independent channels (≥1).
- `CNT_W`, 25: counter and half-period width.
- `DEFAULT_HALF`, 12500000: reset half-period (2 Hz square at 50 MHz).
- `clock` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `run` in NUM_CH: per-channel enable; level in free-run mode, rising edge triggers in one-shot mode.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: configuration accepted when `cfg_valid && cfg_ready`.
- `cfg_ch` in max(1,$clog2(NUM_CH)): target channel.
- `cfg_half` in CNT_W: new half-period H, in clock cycles.
- `cfg_oneshot` in 1: new mode; 1 = one-shot, 0 = free-run.
- `tick` out NUM_CH: one-cycle strobe per terminal count.
- `square` out NUM_CH: toggles at each terminal count.
- `busy` out NUM_CH: channel counting.

## Operation
- Per channel: `cnt` (CNT_W), `half`, `oneshot`, and pending slot (`pend_v`, `pend_half`, `pend_os`). Also `run_q` for edge detection.
- Active condition:
  - Free-run: `busy = run`.
  - One-shot: `busy` sets on `run` rising edge and clears on the channel's tick.
- Active edge:
  - If `cnt >= half`: `tick`←1, `square`←~`square`, `cnt`←1.
  - Else `cnt`←`cnt`+1 and `tick`←0.
- Inactive: `cnt` held at 1, `tick`←0, `square`←0.
- `cfg_half` of 0 is stored as 1. H=1 gives a tick every cycle.
- `cfg_ready` is 0 while `reset` is high. Otherwise `cfg_ready = ~pend_v[cfg_ch]`. Accepted `cfg_ch` ≥ NUM_CH is dropped silently.
- On acceptance, `pend_*` is loaded for that channel.
- Pending is applied (`half`, `oneshot` updated; `pend_v` cleared):
  - at the channel's next terminal-count edge, so the new period starts with the next period;
  - or at the next edge if the channel is inactive.
- Switching to one-shot at a terminal count leaves the channel idle until the next `run` rising edge.
- One-shot corner cases:
  - `run` rising edge while busy: ignored.
  - `run` falling while busy: abort. `busy`←0, `cnt`←1, no tick.
- Channels are fully independent. Simultaneous terminal counts on several channels all strobe in the same cycle.

## Timing
- Reset (sync) values:
  - `tick`=0, `square`=0, `busy`=0, `cnt`=1.
  - `half`=DEFAULT_HALF, `oneshot`=0, `pend_v`=0, `run_q`=0.
- After reset deasserts, `cfg_ready`=1 combinationally.
- `tick`, `square`, `busy` are registered.
- First `tick` asserts in the cycle after the H-th rising edge at which the channel is active. After that, `tick` repeats every H cycles; `square` period is 2H.
- One-shot:
  - `busy` rises one cycle after the `run` edge is sampled.
  - `tick` follows H edges later; `busy` falls in the same cycle `tick` is high.
- Config latency: `cfg_ready` for a channel drops the cycle after acceptance and returns the cycle after the pending slot is applied.
- Reset mid-period: outputs return to reset values at the next edge; pending config is discarded.
- Counter never wraps. `cnt` ≤ `half` ≤ 2^CNT_W−1 is guaranteed by the `>=` compare.

## Structure
- Package `snake_timing_pkg` holds:
  - `SYS_CLK_HZ` = 50000000 and `DEFAULT_HALF`;
  - the eight game speed-level half-periods: 12500000, 10000000, 9000000, 7500000, 6250000, 5000000, 1562500, 781250;
  - a level-to-half function, so the game controller drives `cfg_half` from its 3-bit level.
- Sub-module `rate_channel`: one counter, pending slot, mode logic, edge detect. Instantiated NUM_CH times by generate. The top level contains only the config decode and `cfg_ready` mux.

## Test plan
- Reset, then `run[0]`=1 with `half` forced to 4 via config: `tick[0]` at cycles 4, 8, 12 after enable; `square[0]` period 8; `busy[0]`=1.
- Config ch0 H=3 accepted mid-period (H=5 running): current period completes at 5. The next ticks are 3 apart, and `cfg_ready` is low exactly until the apply edge.
- One-shot ch1 H=6, pulse `run[1]`:
  - exactly one tick, 6 edges after `busy` rises;
  - a second `run` edge during busy is ignored;
  - `busy` clears with the tick.
- `cfg_half`=0 on ch0: stored as 1. `tick[0]` is continuously high and `square[0]` toggles every cycle.
- Both channels at H=2 free-running: simultaneous `tick`=2'b11 every 2 cycles. Synchronous reset asserted mid-count: all outputs 0 and `cnt` reloads to 1 the next edge. A pending config is lost, and `half` reverts to DEFAULT_HALF.

Source files
------------

// File: rtl/snake_timing_pkg.sv
// -----------------------------------------------------------------------------
// snake_timing_pkg
//   Shared timing constants and types for the Snake game rate generator.
//   - SYS_CLK_HZ / DEFAULT_HALF : system clock and reset half-period (2 Hz square)
//   - mode_e                    : per-channel counting mode
//   - level_to_half()           : maps the controller's 3-bit speed level to a
//                                 half-period in clock cycles for cfg_half
// -----------------------------------------------------------------------------
package snake_timing_pkg;

  localparam int unsigned SYS_CLK_HZ   = 50_000_000;
  localparam int unsigned DEFAULT_HALF = 12_500_000;

  localparam int unsigned LEVEL_W    = 3;
  localparam int unsigned NUM_LEVELS = 8;

  typedef logic [LEVEL_W-1:0] level_t;

  // Channel counting mode; the encoding matches the cfg_oneshot pin.
  typedef enum logic {
    MODE_FREE_RUN = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  // Half-periods for game speed levels 0 (slowest) .. 7 (fastest).
  localparam int unsigned LEVEL_HALF [NUM_LEVELS] = '{
    12_500_000, 10_000_000, 9_000_000, 7_500_000,
     6_250_000,  5_000_000, 1_562_500,   781_250
  };

  function automatic int unsigned level_to_half(input level_t level);
    return LEVEL_HALF[level];
  endfunction

endpackage : snake_timing_pkg

// File: rtl/snake_rate_channel.sv
// -----------------------------------------------------------------------------
// rate_channel
//   One tick/square channel: counter, current period and mode, a single-entry
//   pending configuration slot, and run edge detection.
//   Ports:
//     clock, reset        : system clock, synchronous active-high reset
//     run                 : level enable (free-run) / rising-edge trigger (one-shot)
//     load                : accept load_half/load_oneshot into the pending slot
//     load_half           : requested half-period (0 is stored as 1)
//     load_oneshot        : requested mode, 1 = one-shot
//     tick, square, busy  : registered channel outputs
//     pend_v              : pending slot occupied (config port back-pressure)
// -----------------------------------------------------------------------------
module rate_channel
  import snake_timing_pkg::*;
#(
  parameter int unsigned CNT_W        = 25,
  parameter int unsigned DEFAULT_HALF = snake_timing_pkg::DEFAULT_HALF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_half,
  input  logic             load_oneshot,
  output logic             tick,
  output logic             square,
  output logic             busy,
  output logic             pend_v
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  mode_e            mode_q, mode_d;
  mode_e            pend_mode_q, pend_mode_d;
  logic             pend_v_q, pend_v_d;
  logic             run_q, run_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             square_q, square_d;

  logic             run_rise;
  logic             run_fall;
  logic             active;
  logic             terminal;
  logic             apply;

  // NOTE: every signal written here gets its default first, so no path through
  // the block can hold a stale value and infer a latch.
  always_comb begin
    run_rise = run & ~run_q;
    run_fall = ~run & run_q;

    // A one-shot only counts while armed; a falling run aborts it on this edge.
    active   = (mode_q == MODE_ONESHOT) ? (busy_q & ~run_fall) : run;
    terminal = active && (cnt_q >= half_q);

    // Pending config lands on a period boundary, or immediately when idle.
    apply    = pend_v_q && (terminal || !active);

    cnt_d       = cnt_q;
    half_d      = half_q;
    mode_d      = mode_q;
    pend_v_d    = pend_v_q;
    pend_half_d = pend_half_q;
    pend_mode_d = pend_mode_q;
    run_d       = run;
    busy_d      = busy_q;
    tick_d      = 1'b0;
    square_d    = square_q;

    if (active) begin
      if (terminal) begin
        tick_d   = 1'b1;
        square_d = ~square_q;
        cnt_d    = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d    = CNT_W'(1);
      square_d = 1'b0;
    end

    if (mode_q == MODE_ONESHOT) begin
      // Armed: stay busy until the terminal tick. Idle or aborting: arm only
      // on a fresh rising edge (an abort edge can never also be a rise).
      busy_d = active ? ~terminal : (run_rise & ~busy_q);
    end else begin
      busy_d = run;
    end

    if (apply) begin
      half_d   = pend_half_q;
      mode_d   = pend_mode_q;
      pend_v_d = 1'b0;
      // Entering one-shot on a terminal count leaves the channel idle; it only
      // arms here if it was idle and run rose on this very edge.
      busy_d   = (pend_mode_q == MODE_ONESHOT) ? (~active & run_rise) : run;
    end

    if (load) begin
      pend_v_d    = 1'b1;
      pend_half_d = (load_half == '0) ? CNT_W'(1) : load_half;
      pend_mode_d = load_oneshot ? MODE_ONESHOT : MODE_FREE_RUN;
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values
  // computed above, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= CNT_W'(1);
      half_q      <= CNT_W'(DEFAULT_HALF);
      mode_q      <= MODE_FREE_RUN;
      // NOTE: the pending slot is cleared as well, so a config posted before
      // reset can never be applied after it.
      pend_v_q    <= 1'b0;
      pend_half_q <= '0;
      pend_mode_q <= MODE_FREE_RUN;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      square_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      mode_q      <= mode_d;
      pend_v_q    <= pend_v_d;
      pend_half_q <= pend_half_d;
      pend_mode_q <= pend_mode_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      tick_q      <= tick_d;
      square_q    <= square_d;
    end
  end

  assign tick   = tick_q;
  assign square = square_q;
  assign busy   = busy_q;
  assign pend_v = pend_v_q;

endmodule : rate_channel

// File: rtl/snake_rate_generator.sv
// -----------------------------------------------------------------------------
// snake_rate_generator
//   Multi-channel programmable tick / square-wave generator for the Snake game.
//   Ports:
//     clock, reset     : system clock, synchronous active-high reset
//     run[NUM_CH]      : per-channel enable / one-shot trigger
//     cfg_valid/ready  : configuration handshake
//     cfg_ch           : target channel (out-of-range requests are dropped)
//     cfg_half         : new half-period in clock cycles
//     cfg_oneshot      : new mode, 1 = one-shot
//     tick[NUM_CH]     : one-cycle strobe per terminal count
//     square[NUM_CH]   : toggles at each terminal count
//     busy[NUM_CH]     : channel counting
// -----------------------------------------------------------------------------
module snake_rate_generator
  import snake_timing_pkg::*;
#(
  parameter  int unsigned NUM_CH       = 2,
  parameter  int unsigned CNT_W        = 25,
  parameter  int unsigned DEFAULT_HALF = snake_timing_pkg::DEFAULT_HALF,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic              cfg_oneshot,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] square,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] pend_v;
  logic [NUM_CH-1:0] load;

  // Ready mirrors the addressed channel's free pending slot. An out-of-range
  // channel is always ready so the request is consumed and dropped.
  always_comb begin
    cfg_ready = 1'b0;
    if (!reset) begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ch == CH_W'(i)) begin
          cfg_ready = ~pend_v[i];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));

    rate_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_channel (
      .clock        (clock),
      .reset        (reset),
      .run          (run[i]),
      .load         (load[i]),
      .load_half    (cfg_half),
      .load_oneshot (cfg_oneshot),
      .tick         (tick[i]),
      .square       (square[i]),
      .busy         (busy[i]),
      .pend_v       (pend_v[i])
    );
  end

endmodule : snake_rate_generator

// File: tb/tb_snake_rate_generator.sv
// -----------------------------------------------------------------------------
// tb_snake_rate_generator
//   Directed bench for snake_rate_generator. A countdown model derived from the
//   channel rules is compared with the DUT on every falling edge; directed
//   sections add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_snake_rate_generator;
  import snake_timing_pkg::*;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 25;
  localparam int CH_W   = 1;
  localparam int TB_DEF = 10;   // short reset half-period keeps revert checks quick

  logic              clock;
  logic              reset;
  logic [NUM_CH-1:0] run;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic              cfg_oneshot;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] square;
  logic [NUM_CH-1:0] busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  // Model state: m_left counts edges remaining in the current period.
  int m_half      [NUM_CH];
  int m_left      [NUM_CH];
  int m_pend_half [NUM_CH];
  bit m_os        [NUM_CH];
  bit m_pend      [NUM_CH];
  bit m_pend_os   [NUM_CH];
  bit m_busy      [NUM_CH];
  bit m_sq        [NUM_CH];
  bit m_tick      [NUM_CH];
  bit m_prev_run  [NUM_CH];

  snake_rate_generator #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (TB_DEF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_half    (cfg_half),
    .cfg_oneshot (cfg_oneshot),
    .tick        (tick),
    .square      (square),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit r, rise, counting, tc, busy_n, acc;
    int ach;
    ach = int'(cfg_ch);
    acc = cfg_valid && !reset && (ach < NUM_CH) && !m_pend[ach];
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        m_half[c] = TB_DEF; m_left[c] = TB_DEF; m_os[c] = 0; m_pend[c] = 0;
        m_busy[c] = 0; m_sq[c] = 0; m_tick[c] = 0; m_prev_run[c] = 0;
      end else begin
        r        = run[c];
        rise     = r && !m_prev_run[c];
        counting = m_os[c] ? (m_busy[c] && r) : r;
        tc       = 0;
        if (counting) begin
          m_left[c]--;
          tc = (m_left[c] == 0);
        end
        m_tick[c] = tc;
        m_sq[c]   = counting ? (m_sq[c] ^ tc) : 1'b0;
        busy_n    = m_os[c] ? (counting ? !tc : rise) : r;
        if (m_pend[c] && (tc || !counting)) begin
          m_half[c] = m_pend_half[c];
          m_os[c]   = m_pend_os[c];
          m_pend[c] = 0;
          busy_n    = m_os[c] ? (!counting && rise) : r;
        end
        if (tc || !counting) m_left[c] = m_half[c];
        m_busy[c]     = busy_n;
        m_prev_run[c] = r;
      end
    end
    if (acc) begin
      m_pend[ach]      = 1;
      m_pend_half[ach] = (cfg_half == 0) ? 1 : int'(cfg_half);
      m_pend_os[ach]   = cfg_oneshot;
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clock);
    if (cmp_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        check($sformatf("cyc_tick%0d", c),   tick[c],   m_tick[c]);
        check($sformatf("cyc_square%0d", c), square[c], m_sq[c]);
        check($sformatf("cyc_busy%0d", c),   busy[c],   m_busy[c]);
      end
      check("cyc_cfg_ready", cfg_ready,
            !reset && !((int'(cfg_ch) < NUM_CH) && m_pend[int'(cfg_ch)]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic next_edge();
    @(posedge clock);
    #1;
  endtask

  // Present a config request and hold it until accepted (bounded wait).
  task automatic do_cfg(input int ch, input int half, input bit os);
    bit seen;
    seen        = 0;
    cfg_valid   = 1'b1;
    cfg_ch      = ch[CH_W-1:0];
    cfg_half    = half[CNT_W-1:0];
    cfg_oneshot = os;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      seen = (cfg_ready === 1'b1);
    end
    check("cfg_accept", seen, 1);
    @(posedge clock);
    #1;
    cfg_valid = 1'b0;
  endtask

  int unsigned exp_lvl [8] = '{12500000, 10000000, 9000000, 7500000,
                               6250000, 5000000, 1562500, 781250};

  initial begin
    reset = 1'b1; run = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0; cfg_oneshot = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    cmp_en = 1;
    @(negedge clock);
    check("rst_tick",   tick,      0);
    check("rst_square", square,    0);
    check("rst_busy",   busy,      0);
    check("rst_ready",  cfg_ready, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("ready_after_reset", cfg_ready, 1);

    for (int l = 0; l < 8; l++)
      check($sformatf("level_half%0d", l), level_to_half(3'(l)), exp_lvl[l]);

    // 1: ch0 free-run H=4 -> ticks at 4, 8, 12; square period 8.
    do_cfg(0, 4, 0);
    next_edge();
    run[0] = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(posedge clock);
      @(negedge clock);
      check($sformatf("t1_tick_n%0d", n),   tick[0],   (n % 4) == 0);
      check($sformatf("t1_square_n%0d", n), square[0], (n / 4) % 2);
      check($sformatf("t1_busy_n%0d", n),   busy[0],   1);
    end

    // 2: H=5 running, H=3 accepted mid-period -> ticks at 5, 8, 11.
    next_edge();
    run[0] = 1'b0;
    do_cfg(0, 5, 0);
    next_edge();
    run[0] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clock);
      #1;
      if (n == 2) begin cfg_valid = 1'b1; cfg_ch = '0; cfg_half = 3; cfg_oneshot = 1'b0; end
      if (n == 3) cfg_valid = 1'b0;
      @(negedge clock);
      check($sformatf("t2_tick_n%0d", n),  tick[0],   (n == 5) || (n == 8) || (n == 11));
      check($sformatf("t2_ready_n%0d", n), cfg_ready, !((n >= 3) && (n < 5)));
    end

    // 3: ch1 one-shot H=6 -> single tick 6 edges after busy rises.
    next_edge();
    do_cfg(1, 6, 1);
    next_edge();
    run[1] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clock);
      @(negedge clock);
      check($sformatf("t3_busy_n%0d", n), busy[1], (n >= 1) && (n <= 6));
      check($sformatf("t3_tick_n%0d", n), tick[1], n == 7);
    end
    // Abort: run falls while busy -> busy clears, no tick.
    next_edge();
    run[1] = 1'b0;
    next_edge();
    run[1] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clock);
      #1;
      if (n == 3) run[1] = 1'b0;
      @(negedge clock);
      check($sformatf("t3a_busy_n%0d", n), busy[1], n <= 3);
      check($sformatf("t3a_tick_n%0d", n), tick[1], 0);
    end

    // 4: cfg_half = 0 stored as 1 -> tick every cycle, square toggles.
    next_edge();
    run[0] = 1'b0;
    do_cfg(0, 0, 0);
    next_edge();
    run[0] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clock);
      @(negedge clock);
      check($sformatf("t4_tick_n%0d", n),   tick[0],   1);
      check($sformatf("t4_square_n%0d", n), square[0], n % 2);
    end

    // 5: both H=2 -> simultaneous ticks; reset mid-count drops pending H=7.
    next_edge();
    run = '0;
    do_cfg(0, 2, 0);
    do_cfg(1, 2, 0);
    next_edge();
    run = 2'b11;
    for (int n = 1; n <= 18; n++) begin
      @(posedge clock);
      #1;
      if (n == 6) begin cfg_valid = 1'b1; cfg_ch = '0; cfg_half = 7; cfg_oneshot = 1'b0; end
      if (n == 7) cfg_valid = 1'b0;
      if (n == 8) reset = 1'b0;
      @(negedge clock);
      if (n <= 7) begin
        check($sformatf("t5_tick_n%0d", n), tick, ((n % 2) == 0) ? 3 : 0);
        check($sformatf("t5_busy_n%0d", n), busy, 3);
      end
      if (n == 7) check("t5_pending_ready", cfg_ready, 0);
      if (n == 8) begin
        check("t5_rst_tick",   tick,      0);
        check("t5_rst_square", square,    0);
        check("t5_rst_busy",   busy,      0);
        check("t5_rst_ready",  cfg_ready, 1);
      end
      if (n >= 9) check($sformatf("t5_revert_tick_n%0d", n), tick, (n == 18) ? 3 : 0);
      if (n == 7) reset = 1'b1;
    end

    repeat (2) @(posedge clock);
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_snake_rate_generator
